// File: rtl/perceptron_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_pkg
//  Description : Shared FSM state encoding and signed Q-format helpers for
//                the multi-epoch perceptron trainer.
//  Revision    : 1.0 - initial release
// ============================================================================
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        UPD  = 3'd2,
        EEND = 3'd3,
        DONE = 3'd4
    } state_e;

    // Fixed-point 1.0 for a given number of fraction bits
    function automatic logic signed [63:0] q_one(input int frac_w);
        return 64'sd1 <<< frac_w;
    endfunction

    // Clamp a wide signed value into the range of a signed word of 'width' bits
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_trainer_q_mul_sat.sv
`default_nettype none
// ============================================================================
//  Module      : q_mul_sat
//  Description : Signed DATA_W x DATA_W fixed-point multiply, arithmetic
//                shift right by FRAC_W, saturated back to DATA_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_mul_sat
    import perceptron_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 10
) (
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [DATA_W-1:0] p_o
);

    logic signed [2*DATA_W-1:0] full_w;
    logic signed [63:0]         shift_w;

    // Full-precision product, rescaled, then clamped into the word range
    always_comb begin
        full_w  = a_i * b_i;
        shift_w = 64'(full_w) >>> FRAC_W;
        p_o     = DATA_W'(sat_w(shift_w, DATA_W));
    end

endmodule
`default_nettype wire

// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_trainer
//  Description : Multi-epoch online perceptron trainer with a serial datapath
//                and one shared saturating Q-format multiplier.
//                Optional macro PERCEPTRON_ERRCNT_EN adds epoch_errs_o and
//                epoch_pulse_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 10,
    parameter int N_IN      = 2,
    parameter int N_SAMP    = 4,
    parameter int MAX_EPOCH = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic [N_SAMP*N_IN*DATA_W-1:0]      x_i,
    input  logic [N_SAMP-1:0]                  d_i,
    input  logic [DATA_W-1:0]                  u_i,
    input  logic [(N_IN+1)*DATA_W-1:0]         w_init_i,
    output logic [(N_IN+1)*DATA_W-1:0]         w_o,
    output logic [N_SAMP-1:0]                  result_o,
    output logic [$clog2(MAX_EPOCH+1)-1:0]     epoch_cnt_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               converged_o
`ifdef PERCEPTRON_ERRCNT_EN
    ,
    output logic [$clog2(N_SAMP+1)-1:0]        epoch_errs_o,
    output logic                               epoch_pulse_o
`endif
);

    localparam int IDX_W  = $clog2(N_IN + 1);
    localparam int SAMP_W = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
    localparam int EC_W   = $clog2(MAX_EPOCH + 1);
    localparam int ERR_W  = $clog2(N_SAMP + 1);
    localparam int ACC_W  = DATA_W + $clog2(N_IN + 2);

    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(N_IN);
    localparam logic [SAMP_W-1:0]        LAST_SAMP = SAMP_W'(N_SAMP - 1);
    localparam logic [EC_W-1:0]          MAX_EC    = EC_W'(MAX_EPOCH);
    localparam logic [ERR_W-1:0]         ERR_MAX   = ERR_W'(N_SAMP);
    localparam logic signed [DATA_W-1:0] ONE       = DATA_W'(q_one(FRAC_W));

    state_e                    state_q, state_d;
    logic signed [DATA_W-1:0]  w_q [N_IN+1];
    logic signed [DATA_W-1:0]  x_arr [N_SAMP][N_IN+1];
    logic [IDX_W-1:0]          idx_q;
    logic [SAMP_W-1:0]         samp_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [N_SAMP-1:0]         y_vec_q;
    logic [N_SAMP-1:0]         result_q;
    logic                      e_pos_q, e_neg_q;
    logic [ERR_W-1:0]          err_q;
    logic [EC_W-1:0]           epoch_cnt_q;
    logic                      busy_q, done_q, converged_q;

    logic signed [DATA_W-1:0]  mul_a, mul_b, prod;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      y_w, e_pos_w, e_neg_w, last_idx, last_samp;
    logic signed [DATA_W+1:0]  w_sum;
    logic signed [DATA_W-1:0]  w_new;

    // Sample table view: slot 0 is the constant 1.0 that multiplies the bias
    for (genvar s = 0; s < N_SAMP; s++) begin : g_samp
        assign x_arr[s][0] = ONE;
        for (genvar i = 0; i < N_IN; i++) begin : g_in
            assign x_arr[s][i+1] = x_i[(s*N_IN+i)*DATA_W +: DATA_W];
        end
    end

    for (genvar i = 0; i <= N_IN; i++) begin : g_wout
        assign w_o[i*DATA_W +: DATA_W] = w_q[i];
    end

    assign result_o    = result_q;
    assign epoch_cnt_o = epoch_cnt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign converged_o = converged_q;

    q_mul_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    // Shared multiplier operands, accumulation, decision and weight update
    always_comb begin
        last_idx  = (idx_q == LAST_IDX);
        last_samp = (samp_q == LAST_SAMP);
        mul_b     = x_arr[samp_q][idx_q];
        mul_a     = (state_q == UPD) ? signed'(u_i) : w_q[idx_q];
        acc_sum   = ((idx_q == '0) ? {ACC_W{1'b0}} : acc_q) + ACC_W'(prod);
        y_w       = !acc_sum[ACC_W-1] && (acc_sum != '0);
        e_pos_w   = d_i[samp_q] && !y_w;
        e_neg_w   = !d_i[samp_q] && y_w;
        w_sum     = e_pos_q ? ((DATA_W+2)'(w_q[idx_q]) + (DATA_W+2)'(prod))
                            : ((DATA_W+2)'(w_q[idx_q]) - (DATA_W+2)'(prod));
        w_new     = DATA_W'(sat_w(64'(w_sum), DATA_W));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = ACC;
            ACC:  if (last_idx) state_d = UPD;
            UPD:  if (last_idx) state_d = last_samp ? EEND : ACC;
            EEND: begin
                if (err_q == '0 || (epoch_cnt_q + EC_W'(1)) == MAX_EC) state_d = DONE;
                else state_d = ACC;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= N_IN; i++) w_q[i] <= '0;
            idx_q       <= '0;
            samp_q      <= '0;
            acc_q       <= '0;
            y_vec_q     <= '0;
            result_q    <= '0;
            e_pos_q     <= 1'b0;
            e_neg_q     <= 1'b0;
            err_q       <= '0;
            epoch_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i <= N_IN; i++) w_q[i] <= w_init_i[i*DATA_W +: DATA_W];
                        idx_q       <= '0;
                        samp_q      <= '0;
                        err_q       <= '0;
                        epoch_cnt_q <= '0;
                        converged_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ACC: begin
                    acc_q <= acc_sum;
                    if (last_idx) begin
                        idx_q           <= '0;
                        y_vec_q[samp_q] <= y_w;
                        e_pos_q         <= e_pos_w;
                        e_neg_q         <= e_neg_w;
                        if ((e_pos_w || e_neg_w) && err_q != ERR_MAX) err_q <= err_q + ERR_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                UPD: begin
                    if (e_pos_q || e_neg_q) w_q[idx_q] <= w_new;
                    if (last_idx) begin
                        idx_q  <= '0;
                        samp_q <= last_samp ? '0 : samp_q + SAMP_W'(1);
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                EEND: begin
                    epoch_cnt_q <= epoch_cnt_q + EC_W'(1);
                    result_q    <= y_vec_q;
                    if (err_q == '0) converged_q <= 1'b1;
                    err_q <= '0;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PERCEPTRON_ERRCNT_EN
    logic [ERR_W-1:0] epoch_errs_q;

    // Error count of the most recently completed epoch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                epoch_errs_q <= '0;
        else if (state_q == EEND)  epoch_errs_q <= err_q;
    end

    assign epoch_errs_o  = epoch_errs_q;
    assign epoch_pulse_o = (state_q == EEND);
`endif

endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perceptron_trainer
//  Description : Self-checking bench for perceptron_trainer against an
//                epoch-level arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_trainer;

    localparam int DW    = 16;
    localparam int FW    = 10;
    localparam int NI    = 2;
    localparam int NS    = 4;
    localparam int MAXE  = 8;
    localparam int EC_W  = $clog2(MAXE + 1);
    localparam int ER_W  = $clog2(NS + 1);
    localparam int ECYC  = NS * 2 * (NI + 1) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start_i = 1'b0;
    logic [NS*NI*DW-1:0]      x_i = '0;
    logic [NS-1:0]            d_i = '0;
    logic [DW-1:0]            u_i = '0;
    logic [(NI+1)*DW-1:0]     w_init_i = '0;
    logic [(NI+1)*DW-1:0]     w_o;
    logic [NS-1:0]            result_o;
    logic [EC_W-1:0]          epoch_cnt_o;
    logic                     busy_o, done_o, converged_o;
`ifdef PERCEPTRON_ERRCNT_EN
    logic [ER_W-1:0]          epoch_errs_o;
    logic                     epoch_pulse_o;
`endif

    perceptron_trainer #(.DATA_W(DW), .FRAC_W(FW), .N_IN(NI), .N_SAMP(NS), .MAX_EPOCH(MAXE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .x_i         (x_i),
        .d_i         (d_i),
        .u_i         (u_i),
        .w_init_i    (w_init_i),
        .w_o         (w_o),
        .result_o    (result_o),
        .epoch_cnt_o (epoch_cnt_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .converged_o (converged_o)
`ifdef PERCEPTRON_ERRCNT_EN
        ,
        .epoch_errs_o  (epoch_errs_o),
        .epoch_pulse_o (epoch_pulse_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Scenario inputs (integers) and model outputs
    int        xm [NS][NI];
    bit [NS-1:0] dm;
    int        um;
    int        wim [NI+1];
    int        exp_w [NI+1];
    bit [NS-1:0] exp_res;
    int        exp_ep, exp_cyc;
    bit        exp_conv;
    int        exp_errs [$];
    int        obs_errs [$];
    int        obs_cyc;
    bit        obs_timeout;

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int qmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat16(p >>> FW);
    endfunction

    function automatic int xval(input int s, input int i);
        return (i == 0) ? (1 << FW) : xm[s][i-1];
    endfunction

    // Online perceptron rule over whole epochs, plain integer arithmetic
    task automatic model_run();
        int w [NI+1];
        int acc, e, nerr;
        bit y;
        for (int i = 0; i <= NI; i++) w[i] = wim[i];
        exp_ep = 0; exp_conv = 0; exp_errs.delete();
        forever begin
            nerr = 0;
            for (int s = 0; s < NS; s++) begin
                acc = 0;
                for (int i = 0; i <= NI; i++) acc += qmul(w[i], xval(s, i));
                y = (acc > 0);
                exp_res[s] = y;
                e = int'(dm[s]) - int'(y);
                if (e != 0) nerr++;
                for (int i = 0; i <= NI; i++) w[i] = sat16(longint'(w[i]) + e * qmul(um, xval(s, i)));
            end
            exp_ep++;
            exp_errs.push_back(nerr);
            if (nerr == 0) begin exp_conv = 1; break; end
            if (exp_ep == MAXE) break;
        end
        for (int i = 0; i <= NI; i++) exp_w[i] = w[i];
        exp_cyc = 1 + exp_ep * ECYC;
    endtask

    task automatic apply_inputs();
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < NI; i++) x_i[(s*NI+i)*DW +: DW] = DW'(xm[s][i]);
        d_i = dm;
        u_i = DW'(um);
        for (int i = 0; i <= NI; i++) w_init_i[i*DW +: DW] = DW'(wim[i]);
    endtask

    task automatic load_gate(input bit [NS-1:0] d);
        int bits [NS][NI] = '{'{0, 0}, '{1, 0}, '{0, 1}, '{1, 1}};
        for (int s = 0; s < NS; s++)
            for (int i = 0; i < NI; i++) xm[s][i] = bits[s][i] ? 32'h400 : 0;
        dm = d; um = 32'h200;
        for (int i = 0; i <= NI; i++) wim[i] = 0;
    endtask

    // Start a run and wait (bounded) for done; optionally pulse start while busy
    task automatic run_training(input bit poke_busy);
        apply_inputs();
        obs_errs.delete();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        obs_cyc = 0; obs_timeout = 1'b1;
        while (obs_cyc < 3000) begin
            @(negedge clk);
            obs_cyc++;
            start_i = poke_busy && (obs_cyc % 7 == 3) && (obs_cyc < exp_cyc - 2);
`ifdef PERCEPTRON_ERRCNT_EN
            if (epoch_pulse_o) begin
                @(negedge clk);
                obs_cyc++;
                start_i = 1'b0;
                obs_errs.push_back(int'(epoch_errs_o));
            end
`endif
            if (done_o) begin obs_timeout = 1'b0; break; end
        end
        start_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_chk++; if (w_o !== '0) begin n_fail++; $display("FAIL reset_w: got %h expected 0", w_o); end
        n_chk++; if (result_o !== '0) begin n_fail++; $display("FAIL reset_result: got %b expected 0", result_o); end
        n_chk++; if (epoch_cnt_o !== '0) begin n_fail++; $display("FAIL reset_epoch: got %0d expected 0", epoch_cnt_o); end
        n_chk++; if ({busy_o, done_o, converged_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy_o, done_o, converged_o}); end
    endtask

    task automatic test_case(input string tag, input bit poke_busy);
        model_run();
        run_training(poke_busy);
        n_chk++; if (obs_timeout) begin n_fail++; $display("FAIL %s_timeout: no done within 3000 cycles", tag); end
        n_chk++; if (obs_cyc !== exp_cyc) begin n_fail++; $display("FAIL %s_cycles: got %0d expected %0d", tag, obs_cyc, exp_cyc); end
        for (int i = 0; i <= NI; i++) begin
            n_chk++;
            if (w_o[i*DW +: DW] !== DW'(exp_w[i])) begin
                n_fail++; $display("FAIL %s_w%0d: got %h expected %h", tag, i, w_o[i*DW +: DW], DW'(exp_w[i]));
            end
        end
        n_chk++; if (result_o !== exp_res) begin n_fail++; $display("FAIL %s_result: got %b expected %b", tag, result_o, exp_res); end
        n_chk++; if (epoch_cnt_o !== EC_W'(exp_ep)) begin n_fail++; $display("FAIL %s_epochs: got %0d expected %0d", tag, epoch_cnt_o, exp_ep); end
        n_chk++; if (converged_o !== exp_conv) begin n_fail++; $display("FAIL %s_converged: got %b expected %b", tag, converged_o, exp_conv); end
        n_chk++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL %s_idle_flags: got busy=%b done=%b expected 0 0", tag, busy_o, done_o); end
`ifdef PERCEPTRON_ERRCNT_EN
        n_chk++; if (obs_errs != exp_errs) begin n_fail++; $display("FAIL %s_epoch_errs: got %p expected %p", tag, obs_errs, exp_errs); end
`endif
    endtask

    task automatic test_or();
        load_gate(4'b1110);
        test_case("or", 1'b0);
        n_chk++; if (obs_cyc !== 101 || epoch_cnt_o !== EC_W'(4) || converged_o !== 1'b1)
            begin n_fail++; $display("FAIL or_fixed: got cyc=%0d ep=%0d conv=%b expected 101 4 1", obs_cyc, epoch_cnt_o, converged_o); end
        n_chk++; if (w_o !== {16'h0200, 16'h0200, 16'h0000} || result_o !== 4'b1110)
            begin n_fail++; $display("FAIL or_fixed_w: got %h %b expected 020002000000 1110", w_o, result_o); end
    endtask

    task automatic test_and();
        load_gate(4'b1000);
        test_case("and", 1'b0);
    endtask

    task automatic test_xor();
        load_gate(4'b0110);
        test_case("xor", 1'b0);
        n_chk++; if (converged_o !== 1'b0 || epoch_cnt_o !== EC_W'(MAXE) || obs_cyc !== 201)
            begin n_fail++; $display("FAIL xor_fixed: got conv=%b ep=%0d cyc=%0d expected 0 8 201", converged_o, epoch_cnt_o, obs_cyc); end
    endtask

    task automatic test_saturation();
        for (int s = 0; s < NS; s++) for (int i = 0; i < NI; i++) xm[s][i] = 32'h7FFF;
        dm = 4'b1111; um = 32'h7FFF;
        wim[0] = 32'h7000; wim[1] = -32768; wim[2] = -32768;
        test_case("sat", 1'b0);
        n_chk++; if (w_o[DW-1:0] !== 16'h7FFF) begin n_fail++; $display("FAIL sat_clamp: got %h expected 7fff", w_o[DW-1:0]); end
    endtask

    task automatic test_reset_mid();
        load_gate(4'b1110);
        apply_inputs();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (35) @(negedge clk);
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        test_case("or_after_reset", 1'b0);
    endtask

    task automatic test_start_while_busy();
        load_gate(4'b1110);
        test_case("or_busy_start", 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < NS; s++) for (int i = 0; i < NI; i++) xm[s][i] = int'($urandom_range(0, 4096)) - 2048;
            dm = NS'($urandom);
            um = int'($urandom_range(64, 2048));
            for (int i = 0; i <= NI; i++) wim[i] = int'($urandom_range(0, 4096)) - 2048;
            test_case($sformatf("rand%0d", r), 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_or();
        test_and();
        test_xor();
        test_saturation();
        test_reset_mid();
        test_start_while_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
